counter_sched: RTL and testbench

- Round-robin scheduler that shares one external 8-bit counter (ports clock/clear/count/Q) between NREQ requesters.
- Each requester issues one operation: read, increment or clear. The block sequences the counter's clear/count strobes, captures the resulting Q and returns it with a one-cycle acknowledge.
- Sits between client logic and the counter instance. It is the only driver of the counter's clear and count inputs.

---
 rtl/counter_sched.sv | 120 ++++++++++++
 tb/tb_counter_sched.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/counter_sched.sv
// rtl/counter_sched.sv - round-robin scheduler sharing one external counter between NREQ requesters
// Optional build macro: COUNTER_SCHED_SATURATE_EN (increment at all-ones holds instead of wrapping).
`timescale 1ns/1ps
module counter_sched #(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_i,
  input  logic [2*NREQ-1:0] op_i,
  output logic [NREQ-1:0]   ack_o,
  output logic [W-1:0]      rdata_o,
  output logic              wrap_o,
  output logic              busy_o,
  output logic              ctr_clear_o,
  output logic              ctr_count_o,
  input  logic [W-1:0]      ctr_q_i
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [1:0] OP_INC = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;

  typedef enum logic [1:0] {INIT, IDLE, ISSUE, CAPTURE} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] ptr, win, gidx;
  logic [IW:0]   cand;
  logic [1:0]    wop;
  logic          gvalid;
  logic          wrap_pending, wrap_q;
  logic [W-1:0]  rdata_q;
  logic          is_inc, q_full, cnt_en;

  assign is_inc = (wop == OP_INC);
  assign q_full = &ctr_q_i;

`ifdef COUNTER_SCHED_SATURATE_EN
  assign cnt_en = is_inc && !q_full;
`else
  assign cnt_en = is_inc;
`endif

  // Descending scan so the candidate closest to ptr+1 is the last one assigned.
  always_comb begin
    gvalid = 1'b0;
    gidx   = '0;
    cand   = '0;
    for (int i = NREQ; i >= 1; i--) begin
      cand = (IW+1)'(ptr) + (IW+1)'(i);
      if (cand >= (IW+1)'(NREQ))
        cand = cand - (IW+1)'(NREQ);
      if (req_i[cand[IW-1:0]]) begin
        gvalid = 1'b1;
        gidx   = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    ctr_clear_o = 1'b0;
    ctr_count_o = 1'b0;
    ack_o       = '0;
    rdata_o     = rdata_q;
    wrap_o      = wrap_q;
    case (state)
      INIT: begin
        // Gated so the clear strobe stays low while reset is held.
        ctr_clear_o = reset_n;
        state_nxt   = IDLE;
      end
      IDLE: begin
        if (gvalid)
          state_nxt = ISSUE;
      end
      ISSUE: begin
        ctr_count_o = cnt_en;
        ctr_clear_o = (wop == OP_CLR);
        state_nxt   = CAPTURE;
      end
      CAPTURE: begin
        ack_o     = NREQ'(1) << win;
        rdata_o   = ctr_q_i;
        wrap_o    = wrap_pending;
        state_nxt = IDLE;
      end
      default: state_nxt = INIT;
    endcase
  end

  assign busy_o = (state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= INIT;
      ptr          <= '0;
      win          <= '0;
      wop          <= 2'b00;
      wrap_pending <= 1'b0;
      rdata_q      <= '0;
      wrap_q       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && gvalid) begin
        win <= gidx;
        wop <= op_i[{gidx, 1'b0} +: 2];
      end
      if (state == ISSUE)
        wrap_pending <= is_inc && q_full;
      if (state == CAPTURE) begin
        ptr     <= win;
        rdata_q <= ctr_q_i;
        wrap_q  <= wrap_pending;
      end
    end
  end

endmodule

// File: tb/tb_counter_sched.sv
// tb/tb_counter_sched.sv - directed bench for counter_sched with a behavioural 8-bit counter
`timescale 1ns/1ps
module tb_counter_sched;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam logic [1:0] RD  = 2'b00;
  localparam logic [1:0] INC = 2'b01;
  localparam logic [1:0] CLR = 2'b10;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req_i;
  logic [2*NREQ-1:0] op_i;
  logic [NREQ-1:0]   ack_o;
  logic [W-1:0]      rdata_o;
  logic              wrap_o, busy_o, ctr_clear_o, ctr_count_o;
  logic [W-1:0]      cq = 8'h5A;
  logic              load = 1'b0;
  logic [W-1:0]      load_val = '0;

  int vectors = 0;
  int miscompares = 0;
  int order [4] = '{1, 2, 3, 0};

  counter_sched #(.NREQ(NREQ), .W(W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_i       (req_i),
    .op_i        (op_i),
    .ack_o       (ack_o),
    .rdata_o     (rdata_o),
    .wrap_o      (wrap_o),
    .busy_o      (busy_o),
    .ctr_clear_o (ctr_clear_o),
    .ctr_count_o (ctr_count_o),
    .ctr_q_i     (cq)
  );

  always #5 clock = ~clock;

  // External counter: no reset, synchronous clear has priority over count.
  always @(posedge clock) begin
    if (load)             cq <= load_val;
    else if (ctr_clear_o) cq <= '0;
    else if (ctr_count_o) cq <= cq + 8'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic service(input int k, input logic [1:0] op, input logic exp_clr,
                         input logic exp_cnt, input logic [W-1:0] exp_q,
                         input logic exp_wrap, input string tag);
    @(negedge clock);
    chk({tag, " idle busy"}, busy_o, 0);
    req_i[k] = 1'b1;
    op_i[2*k +: 2] = op;
    @(negedge clock);
    chk({tag, " issue ack"}, ack_o, 0);
    chk({tag, " issue strobes"}, {ctr_clear_o, ctr_count_o}, {exp_clr, exp_cnt});
    @(negedge clock);
    chk({tag, " ack"}, ack_o, 32'(1) << k);
    chk({tag, " rdata"}, rdata_o, exp_q);
    chk({tag, " wrap"}, wrap_o, exp_wrap);
    req_i[k] = 1'b0;
  endtask

  task automatic load_counter(input logic [W-1:0] v);
    @(negedge clock);
    load = 1'b1;
    load_val = v;
    @(negedge clock);
    load = 1'b0;
    chk("preload", cq, v);
  endtask

  initial begin
    reset_n = 1'b0;
    req_i   = '0;
    op_i    = '0;

    // Reset state and INIT clear
    repeat (2) @(negedge clock);
    chk("rst ack", ack_o, 0);
    chk("rst busy", busy_o, 1);
    chk("rst strobes", {ctr_clear_o, ctr_count_o}, 0);
    chk("rst rdata", rdata_o, 0);
    chk("rst wrap", wrap_o, 0);
    reset_n = 1'b1;
    #1;
    chk("init clear", ctr_clear_o, 1);
    chk("init busy", busy_o, 1);
    @(negedge clock);
    chk("post-init clear", ctr_clear_o, 0);
    chk("post-init busy", busy_o, 0);
    chk("post-init q", cq, 0);

    // Back-to-back increments from requester 0
    service(0, INC, 0, 1, 8'd1, 0, "inc1");
    service(0, INC, 0, 1, 8'd2, 0, "inc2");
    service(0, INC, 0, 1, 8'd3, 0, "inc3");
    @(negedge clock);
    chk("hold ack", ack_o, 0);
    chk("hold rdata", rdata_o, 3);

    // Fresh reset, then all four request increments at once
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    req_i = 4'b1111;
    op_i  = 8'b01010101;
    for (int n = 0; n < 4; n++) begin
      repeat ((n == 0) ? 2 : 3) @(negedge clock);
      chk("rr ack", ack_o, 32'(1) << order[n]);
      chk("rr rdata", rdata_o, n + 1);
      req_i[order[n]] = 1'b0;
    end

    // Top-of-range increments
    load_counter(8'hFE);
    service(1, INC, 0, 1, 8'hFF, 0, "top1");
`ifdef COUNTER_SCHED_SATURATE_EN
    service(1, INC, 0, 0, 8'hFF, 1, "top2");
`else
    service(1, INC, 0, 1, 8'h00, 1, "top2");
`endif
    @(negedge clock);
    chk("wrap hold", wrap_o, 1);

    // Read and clear contend, read wins from ptr=1
    load_counter(8'h2A);
    @(negedge clock);
    chk("rc idle", busy_o, 0);
    req_i[2] = 1'b1;
    req_i[3] = 1'b1;
    op_i[5:4] = RD;
    op_i[7:6] = CLR;
    @(negedge clock);
    chk("rd strobes", {ctr_clear_o, ctr_count_o}, 0);
    @(negedge clock);
    chk("rd ack", ack_o, 4'b0100);
    chk("rd rdata", rdata_o, 8'h2A);
    req_i[2] = 1'b0;
    @(negedge clock);
    chk("clr idle ack", ack_o, 0);
    @(negedge clock);
    chk("clr strobes", {ctr_clear_o, ctr_count_o}, 2'b10);
    @(negedge clock);
    chk("clr ack", ack_o, 4'b1000);
    chk("clr rdata", rdata_o, 0);
    req_i[3] = 1'b0;

    // Reset during ISSUE
    @(negedge clock);
    req_i[0] = 1'b1;
    op_i[1:0] = INC;
    @(negedge clock);
    chk("mid issue count", ctr_count_o, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid strobes", {ctr_clear_o, ctr_count_o}, 0);
    chk("mid ack", ack_o, 0);
    chk("mid busy", busy_o, 1);
    req_i[0] = 1'b0;
    for (int n = 0; n < 2; n++) begin
      @(negedge clock);
      chk("mid held ack", ack_o, 0);
    end
    chk("mid no count", cq, 0);
    reset_n = 1'b1;
    #1;
    chk("mid init clear", ctr_clear_o, 1);
    @(negedge clock);
    chk("mid post busy", busy_o, 0);
    chk("mid post q", cq, 0);
    service(0, INC, 0, 1, 8'd1, 0, "after");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
